dot_acc: RTL and testbench
==========================

Name: dot_acc

Overview:
- Sequential dot-product accumulator directly downstream of the 2-input fixed-point multiplier in the LSTM datapath.
- Consumes a stream of NUM rounded Q(WIDTH-FRAC).FRAC products, adds them to a bias in a guard-extended register, and emits one saturated WIDTH-bit sum per dot product.
- The sum goes to the gate activation stage through a valid/ready handshake.

Parameters:
- WIDTH, 32, data width of products, bias and sum (two's complement).
- FRAC, 24, fractional bits. All operands share this format, so no realignment is done.
- NUM, 8, products per dot product. Legal range is 1 to 2^GUARD-1.
- GUARD, 8, extra accumulator MSBs. The accumulator is WIDTH+GUARD bits wide.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- i_start, input, 1, begin a new dot product. Sampled only in IDLE.
- i_bias, input, WIDTH, bias loaded when i_start is accepted.
- i_valid, input, 1, i_prod carries a valid product.
- i_prod, input, WIDTH, product from the multiplier.
- o_ready, output, 1, block accepts i_prod this cycle.
- i_ready, input, 1, downstream accepts o_sum.
- o_valid, output, 1, o_sum holds a completed result.
- o_sum, output, WIDTH, saturated dot-product result.
- o_busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, active-high, clk edge with rst=1):
  - state to IDLE; acc, cnt, o_sum to 0.
  - o_valid, o_ready and o_busy read 0 in the following cycle.
  - rst overrides every other input.
  - Reset mid-operation discards the partial sum; no o_valid is produced.
- States are IDLE, ACC and DONE. They are registered, and o_ready, o_valid and o_busy decode from them.
- IDLE:
  - o_ready=0.
  - On i_start=1: acc <= sign-extend(i_bias) to WIDTH+GUARD, cnt <= 0, next state ACC.
  - i_valid and i_ready are ignored.
- ACC:
  - o_ready=1.
  - An edge with i_valid=1 accepts a product: acc <= acc + sign-extend(i_prod), cnt <= cnt+1.
  - i_valid=0 leaves acc and cnt held. Gaps of any length are allowed.
  - Accepting the product when cnt==NUM-1:
    - o_sum <= sat(acc + sign-extend(i_prod)).
    - next state DONE.
  - i_start is ignored.
- DONE:
  - o_valid=1, o_ready=0.
  - o_sum and o_valid are held stable until an edge with i_ready=1; that edge goes to IDLE.
  - i_start in the same cycle as the handshake is ignored. A new start needs IDLE.
- Latency:
  - o_valid rises in the cycle after the edge that accepts the last product.
  - Minimum period per result is NUM+2 cycles: 1 start, NUM products, 1 handshake.
- sat():
  - If acc > 2^(WIDTH-1)-1, output 0x7FFFFFFF.
  - If acc < -2^(WIDTH-1), output 0x80000000.
  - Otherwise output acc[WIDTH-1:0].
  - No rounding and no truncation of fraction bits.
- Internal overflow cannot occur for the legal NUM range: |bias + NUM products| < 2^(WIDTH+GUARD-1).
  - An elaboration-time check fails if NUM >= 2^GUARD or NUM < 1.
- cnt width is clog2(NUM+1). cnt never wraps because the state leaves ACC at NUM-1.
- i_prod, i_bias and i_start are don't-care when not sampled. X on them must not propagate to acc.

Decomposition:
- Shared package lstm_pkg holds WIDTH=32, FRAC=24, the Q-format constants ONE=0x01000000, MAX=0x7FFFFFFF and MIN=0x80000000, and the dot_acc state encoding.
- One natural sub-module, sat_narrow: combinational saturating narrowing from WIDTH+GUARD to WIDTH bits. The activation stage reuses it.

Test Plan:
- Basic sum:
  - Stimulus: NUM=4, bias 0; products 0x01000000, 0x02000000, 0xFF800000 (-0.5), 0x00400000 (0.25), back-to-back.
  - Response: o_valid 1 cycle after the 4th accept, o_sum=0x02C00000 (2.75); DONE lasts 1 cycle with i_ready=1.
- Bias and gaps:
  - Stimulus: NUM=4, bias 0x00800000; the same four products, separated by 0, 3, 1 idle cycles.
  - Response: o_sum=0x03400000; acc unchanged during gaps; o_valid 1 cycle after the last accept.
- Saturation:
  - NUM=4, bias 0, four products 0x7F000000 -> o_sum=0x7FFFFFFF.
  - NUM=4, bias 0x80000000, four products 0xC0000000 -> o_sum=0x80000000.
- Backpressure:
  - Stimulus: hold i_ready=0 for 5 cycles in DONE and pulse i_start plus i_valid during that time.
  - Response: o_valid and o_sum stay stable, o_ready=0, nothing accepted. After i_ready=1, next cycle shows o_valid=0 and o_busy=0.
- Reset mid-run:
  - Stimulus: assert rst after 2 of 4 products.
  - Response: next cycle o_busy=0, o_valid=0, o_sum=0. A new run with bias 0 and four 0x01000000 gives 0x04000000 (no residue).
- Ignored inputs:
  - i_valid pulses in IDLE and i_start pulses in ACC -> no acc/cnt change.
  - The run result equals the clean-run value.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM fixed-point datapath.
// Holds the common word format (Q8.24 in WIDTH bits), the named Q-format
// constants used by several stages, and the dot_acc state encoding.
package lstm_pkg;

  localparam int WIDTH = 32;
  localparam int FRAC  = 24;

  localparam logic [WIDTH-1:0] ONE = 32'h0100_0000;  // 1.0 in Q8.24
  localparam logic [WIDTH-1:0] MAX = 32'h7FFF_FFFF;  // largest positive value
  localparam logic [WIDTH-1:0] MIN = 32'h8000_0000;  // most negative value

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } dot_acc_state_e;

endpackage

// File: rtl/sat_narrow.sv
// Combinational saturating narrowing of a two's-complement value.
// Ports:
//   in_i  : IN_W-bit signed value
//   out_o : OUT_W-bit signed value, clamped to the OUT_W range
// Shared by dot_acc and the gate activation stage.
module sat_narrow #(
  parameter int IN_W  = 40,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o
);

  // Bits from the input MSB down to the output sign bit. The value fits in
  // OUT_W bits exactly when all of them agree.
  localparam int TOP_W = IN_W - OUT_W + 1;

  logic [TOP_W-1:0] top;

  assign top = in_i[IN_W-1:OUT_W-1];

  // NOTE: every output of an always_comb gets a value on every path (default
  // first), otherwise synthesis infers a latch.
  always_comb begin
    out_o = in_i[OUT_W-1:0];
    if (!(top == '0 || top == '1)) begin
      out_o = in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                           : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/dot_acc.sv
// Sequential dot-product accumulator behind the LSTM multiplier.
// Loads a bias on i_start, adds NUM products in a guard-extended register,
// then presents the saturated WIDTH-bit sum on a valid/ready handshake.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   i_start, i_bias   : start a dot product (IDLE only) with this bias
//   i_valid, i_prod   : product stream; accepted while o_ready=1
//   o_ready           : high in ACC
//   i_ready           : downstream accepts o_sum
//   o_valid, o_sum    : completed, saturated result (held in DONE)
//   o_busy            : high whenever not IDLE
module dot_acc #(
  parameter int WIDTH = lstm_pkg::WIDTH,
  parameter int FRAC  = lstm_pkg::FRAC,
  parameter int NUM   = 8,
  parameter int GUARD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_bias,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_prod,
  output logic             o_ready,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_busy
);

  import lstm_pkg::*;

  localparam int AW    = WIDTH + GUARD;
  localparam int CNT_W = $clog2(NUM + 1);

  // The guard bits only cover NUM < 2^GUARD additions without overflow.
  if (NUM < 1 || NUM >= (1 << GUARD) || FRAC >= WIDTH) begin : g_bad_params
    $error("dot_acc: illegal parameters NUM=%0d GUARD=%0d FRAC=%0d", NUM, GUARD, FRAC);
  end

  dot_acc_state_e   state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  logic [AW-1:0]    acc_sum;
  logic [WIDTH-1:0] acc_sat;
  logic             accept;
  logic             last;

  assign accept  = (state_q == ST_ACC) && i_valid;
  assign last    = (cnt_q == CNT_W'(NUM - 1));
  assign acc_sum = acc_q + {{GUARD{i_prod[WIDTH-1]}}, i_prod};

  sat_narrow #(
    .IN_W (AW),
    .OUT_W(WIDTH)
  ) u_sat (
    .in_i (acc_sum),
    .out_o(acc_sat)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_start)       state_d = ST_ACC;
      ST_ACC:  if (accept && last) state_d = ST_DONE;
      ST_DONE: if (i_ready)       state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  // Outputs decode from the registered state only.
  always_comb begin
    o_ready = (state_q == ST_ACC);
    o_valid = (state_q == ST_DONE);
    o_busy  = (state_q != ST_IDLE);
  end

  // Datapath next-state. Operands are only selected on the cycle they are
  // sampled, so unknowns on idle inputs never reach acc_q or sum_q.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    if (state_q == ST_IDLE && i_start) begin
      acc_d = {{GUARD{i_bias[WIDTH-1]}}, i_bias};
      cnt_d = '0;
    end else if (accept) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) sum_d = acc_sat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
    end
  end

  assign o_sum = sum_q;

endmodule

// File: tb/tb_dot_acc.sv
// Self-checking bench for dot_acc with NUM=4.
module tb_dot_acc;

  localparam int W   = 32;
  localparam int NUM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [W-1:0]  i_bias;
  logic          i_valid;
  logic [W-1:0]  i_prod;
  logic          o_ready;
  logic          i_ready;
  logic          o_valid;
  logic [W-1:0]  o_sum;
  logic          o_busy;

  always #5 clk = ~clk;

  dot_acc #(
    .WIDTH(W),
    .FRAC (24),
    .NUM  (NUM),
    .GUARD(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_start(i_start),
    .i_bias (i_bias),
    .i_valid(i_valid),
    .i_prod (i_prod),
    .o_ready(o_ready),
    .i_ready(i_ready),
    .o_valid(o_valid),
    .o_sum  (o_sum),
    .o_busy (o_busy)
  );

  typedef struct packed {
    logic [W-1:0]          bias;
    logic [NUM-1:0][W-1:0] prod;
    logic [NUM-1:0][3:0]   gap;   // idle cycles before each product
    logic [3:0]            hold;  // cycles with i_ready=0 in DONE
    logic [W-1:0]          expv;
  } vec_t;

  vec_t         vecs[8];
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [W-1:0] b,
                              input logic [W-1:0] p0, input logic [W-1:0] p1,
                              input logic [W-1:0] p2, input logic [W-1:0] p3,
                              input logic [3:0] g1, input logic [3:0] g2,
                              input logic [3:0] g3, input logic [3:0] h,
                              input logic [W-1:0] e);
    vec_t v;
    v.bias    = b;
    v.prod[0] = p0;
    v.prod[1] = p1;
    v.prod[2] = p2;
    v.prod[3] = p3;
    v.gap[0]  = 4'd0;
    v.gap[1]  = g1;
    v.gap[2]  = g2;
    v.gap[3]  = g3;
    v.hold    = h;
    v.expv    = e;
    return v;
  endfunction

  // One full transaction: ignored IDLE traffic, start, products with gaps
  // (carrying ignored i_start/garbage), result check, backpressure, handshake.
  task automatic run_vec(input string tag, input vec_t v);
    logic [W-1:0] exp_sum;
    int waited;

    i_valid = 1'b1;
    i_prod  = $urandom;
    tick();
    i_valid = 1'b0;
    check({tag, " idle ignores valid"}, {31'd0, o_busy}, 32'd0);

    i_start = 1'b1;
    i_bias  = v.bias;
    exp_q.push_back(v.expv);
    tick();
    i_start = 1'b0;
    i_bias  = $urandom;
    check({tag, " busy after start"}, {31'd0, o_busy}, 32'd1);
    check({tag, " ready in acc"}, {31'd0, o_ready}, 32'd1);

    for (int k = 0; k < NUM; k++) begin
      for (int g = 0; g < int'(v.gap[k]); g++) begin
        i_valid = 1'b0;
        i_prod  = $urandom;
        i_start = 1'(g % 2 == 0);
        tick();
        check({tag, " no valid during gap"}, {31'd0, o_valid}, 32'd0);
      end
      i_start = 1'b0;
      i_valid = 1'b1;
      i_prod  = v.prod[k];
      tick();
      i_valid = 1'b0;
      i_prod  = $urandom;
    end

    waited = 0;
    while (!o_valid && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, " valid latency"}, 32'(waited), 32'd0);
    check({tag, " ready low in done"}, {31'd0, o_ready}, 32'd0);
    exp_sum = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, " sum"}, o_sum, exp_sum);

    for (int h = 0; h < int'(v.hold); h++) begin
      i_ready = 1'b0;
      i_start = 1'b1;
      i_valid = 1'b1;
      i_prod  = $urandom;
      tick();
      check({tag, " hold valid"}, {31'd0, o_valid}, 32'd1);
      check({tag, " hold sum"}, o_sum, exp_sum);
      check({tag, " hold ready"}, {31'd0, o_ready}, 32'd0);
    end

    // Handshake with a simultaneous start that must be ignored.
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_ready = 1'b0;
    i_start = 1'b0;
    check({tag, " valid after handshake"}, {31'd0, o_valid}, 32'd0);
    check({tag, " busy after handshake"}, {31'd0, o_busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'h0, 32'h0100_0000, 32'h0200_0000, 32'hFF80_0000, 32'h0040_0000,
                 4'd0, 4'd0, 4'd0, 4'd0, 32'h02C0_0000);
    vecs[1] = mk(32'h0080_0000, 32'h0100_0000, 32'h0200_0000, 32'hFF80_0000, 32'h0040_0000,
                 4'd0, 4'd3, 4'd1, 4'd0, 32'h0340_0000);
    vecs[2] = mk(32'h0, 32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000, 32'h7F00_0000,
                 4'd0, 4'd0, 4'd0, 4'd0, 32'h7FFF_FFFF);
    vecs[3] = mk(32'h8000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000,
                 4'd0, 4'd0, 4'd0, 4'd0, 32'h8000_0000);
    // Partial sums cross the WIDTH range but the final sum fits: guard bits matter.
    vecs[4] = mk(32'h7FFF_FFFF, 32'h1, 32'h1, 32'h1, 32'hFFFF_FFFC,
                 4'd1, 4'd0, 4'd2, 4'd0, 32'h7FFF_FFFE);
    vecs[5] = mk(32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h3,
                 4'd0, 4'd0, 4'd0, 4'd0, 32'h8000_0002);
    vecs[6] = mk(32'h0, 32'h0100_0000, 32'h0200_0000, 32'hFF80_0000, 32'h0040_0000,
                 4'd0, 4'd0, 4'd0, 4'd5, 32'h02C0_0000);
    vecs[7] = mk(32'h0, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000,
                 4'd0, 4'd0, 4'd0, 4'd0, 32'h0400_0000);

    rst     = 1'b1;
    i_start = 1'b0;
    i_bias  = '0;
    i_valid = 1'b0;
    i_prod  = '0;
    i_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", {31'd0, o_busy}, 32'd0);
    check("reset valid", {31'd0, o_valid}, 32'd0);
    check("reset ready", {31'd0, o_ready}, 32'd0);
    check("reset sum", o_sum, 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset after two of four products: partial sum is discarded.
    i_start = 1'b1;
    i_bias  = 32'h0300_0000;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_valid = 1'b1;
      i_prod  = 32'h0100_0000;
      tick();
    end
    rst    = 1'b1;
    i_prod = 32'h0100_0000;
    tick();
    rst     = 1'b0;
    i_valid = 1'b0;
    check("midrst busy", {31'd0, o_busy}, 32'd0);
    check("midrst valid", {31'd0, o_valid}, 32'd0);
    check("midrst ready", {31'd0, o_ready}, 32'd0);
    check("midrst sum", o_sum, 32'd0);

    run_vec("after_rst", vecs[7]);

    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
